// File: rtl/mdu.sv
// rtl/mdu.sv - E-stage multiply/divide unit that owns the HI/LO registers
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic [CW-1:0] counter_q, counter_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;

    // One shared unsigned divider; signed division works on magnitudes and fixes signs afterwards.
    always_comb begin
        prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u     = {32'b0, A} * {32'b0, B};
        div_signed = div;
        a_mag      = (div_signed && A[31]) ? (~A + 32'd1) : A;
        b_mag      = (div_signed && B[31]) ? (~B + 32'd1) : B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem        = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        counter_d = counter_q;
        if (counter_q != '0) begin
            counter_d = counter_q - CNT_ONE;
            if (counter_q == CNT_ONE) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (mult) begin
            {pend_hi_d, pend_lo_d} = prod_s;
            counter_d = MULT_CNT;
        end else if (multu) begin
            {pend_hi_d, pend_lo_d} = prod_u;
            counter_d = MULT_CNT;
        end else if (div || divu) begin
            // Divide by zero commits the current HI/LO back, leaving them unchanged.
            if (B == 32'd0) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
            end else begin
                pend_hi_d = rem;
                pend_lo_d = quot;
            end
            counter_d = DIV_CNT;
        end else if (mthi) begin
            hi_d = A;
        end else if (mtlo) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            counter_q <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            counter_q <= counter_d;
        end
    end

    assign start = mult | multu | div | divu;
    assign busy  = (counter_q != '0);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
